// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates the memory line port between I-cache fills and D-cache fills/write-backs
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   reqI_mem, reqAddrI_mem                          I-cache line fill request (level) and address
//   reqD_mem, reqD_write, reqAddrD_mem, reqD_wdata  D-cache request (level), 1=write-back, address, line
//   instr_from_mem, read_ready_I                    I fill data and its one-cycle valid pulse
//   data_from_mem, read_ready_D                     D fill data and its one-cycle valid pulse
//   written_data_ack_D                              one-cycle write-back completion pulse
//   mem_req, mem_we, mem_addr, mem_wdata            memory request side, held for a whole transaction
//   mem_rdata, mem_ready                            memory read line and one-cycle completion pulse
//   busy                                            high whenever a transaction is granted or responding
module mem_port_arbiter #(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reqI_mem,
    input  logic [ADDR_W-1:0] reqAddrI_mem,
    input  logic              reqD_mem,
    input  logic              reqD_write,
    input  logic [ADDR_W-1:0] reqAddrD_mem,
    input  logic [LINE_W-1:0] reqD_wdata,
    output logic [LINE_W-1:0] instr_from_mem,
    output logic              read_ready_I,
    output logic [LINE_W-1:0] data_from_mem,
    output logic              read_ready_D,
    output logic              written_data_ack_D,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        I_RD,
        D_RD,
        D_WR,
        RESP
    } state_t;

    state_t state;
    // 0 = I owned the previous transaction, 1 = D did; a tie goes to the other side.
    logic   last_grant_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            last_grant_d       <= 1'b0;
            instr_from_mem     <= '0;
            data_from_mem      <= '0;
            read_ready_I       <= 1'b0;
            read_ready_D       <= 1'b0;
            written_data_ack_D <= 1'b0;
            mem_req            <= 1'b0;
            mem_we             <= 1'b0;
            mem_addr           <= '0;
            mem_wdata          <= '0;
            busy               <= 1'b0;
        end else begin
            // Response pulses are one cycle wide by construction.
            read_ready_I       <= 1'b0;
            read_ready_D       <= 1'b0;
            written_data_ack_D <= 1'b0;

            case (state)
                IDLE: begin
                    // D wins when alone, or on a tie when I had the last grant.
                    if (reqD_mem && (!reqI_mem || !last_grant_d)) begin
                        mem_req  <= 1'b1;
                        busy     <= 1'b1;
                        mem_addr <= reqAddrD_mem;
                        if (reqD_write) begin
                            state     <= D_WR;
                            mem_we    <= 1'b1;
                            mem_wdata <= reqD_wdata;
                        end else begin
                            state <= D_RD;
                        end
                    end else if (reqI_mem) begin
                        state    <= I_RD;
                        mem_req  <= 1'b1;
                        busy     <= 1'b1;
                        mem_addr <= reqAddrI_mem;
                    end
                end

                I_RD, D_RD, D_WR: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= RESP;
                        case (state)
                            I_RD: begin
                                instr_from_mem <= mem_rdata;
                                read_ready_I   <= 1'b1;
                                last_grant_d   <= 1'b0;
                            end
                            D_RD: begin
                                data_from_mem <= mem_rdata;
                                read_ready_D  <= 1'b1;
                                last_grant_d  <= 1'b1;
                            end
                            default: begin
                                written_data_ack_D <= 1'b1;
                                last_grant_d       <= 1'b1;
                            end
                        endcase
                    end
                end

                // Requests are deliberately ignored for one cycle so the owner can drop its level.
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              reset;
    logic              reqI_mem;
    logic [ADDR_W-1:0] reqAddrI_mem;
    logic              reqD_mem;
    logic              reqD_write;
    logic [ADDR_W-1:0] reqAddrD_mem;
    logic [LINE_W-1:0] reqD_wdata;
    logic [LINE_W-1:0] instr_from_mem;
    logic              read_ready_I;
    logic [LINE_W-1:0] data_from_mem;
    logic              read_ready_D;
    logic              written_data_ack_D;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              busy;

    mem_port_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk                (clk),
        .reset              (reset),
        .reqI_mem           (reqI_mem),
        .reqAddrI_mem       (reqAddrI_mem),
        .reqD_mem           (reqD_mem),
        .reqD_write         (reqD_write),
        .reqAddrD_mem       (reqAddrD_mem),
        .reqD_wdata         (reqD_wdata),
        .instr_from_mem     (instr_from_mem),
        .read_ready_I       (read_ready_I),
        .data_from_mem      (data_from_mem),
        .read_ready_D       (read_ready_D),
        .written_data_ack_D (written_data_ack_D),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_rdata          (mem_rdata),
        .mem_ready          (mem_ready),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_value(input string tag, input logic [LINE_W-1:0] observed,
                               input logic [LINE_W-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference model: one transaction in flight (owner + kind), a response cycle
    // after completion, and a remembered previous owner for tie-breaking.
    logic              m_active, m_in_resp, m_owner_i, m_owner_wr, m_prev_d;
    logic [ADDR_W-1:0] e_addr;
    logic [LINE_W-1:0] e_wdata, e_instr, e_data;
    logic              e_rdy_i, e_rdy_d, e_ack;

    task automatic model_reset();
        m_active = 0; m_in_resp = 0; m_owner_i = 0; m_owner_wr = 0; m_prev_d = 0;
        e_addr = '0; e_wdata = '0; e_instr = '0; e_data = '0;
        e_rdy_i = 0; e_rdy_d = 0; e_ack = 0;
    endtask

    task automatic model_step();
        logic take_d;
        e_rdy_i = 0; e_rdy_d = 0; e_ack = 0;
        if (m_in_resp) begin
            m_in_resp = 0;
        end else if (m_active) begin
            if (mem_ready) begin
                if (m_owner_i) begin
                    e_instr = mem_rdata; e_rdy_i = 1;
                end else if (m_owner_wr) begin
                    e_ack = 1;
                end else begin
                    e_data = mem_rdata; e_rdy_d = 1;
                end
                m_prev_d  = !m_owner_i;
                m_active  = 0;
                m_in_resp = 1;
            end
        end else begin
            take_d = reqD_mem && (!reqI_mem || !m_prev_d);
            if (take_d) begin
                m_active = 1; m_owner_i = 0; m_owner_wr = reqD_write; e_addr = reqAddrD_mem;
                if (reqD_write) e_wdata = reqD_wdata;
            end else if (reqI_mem) begin
                m_active = 1; m_owner_i = 1; m_owner_wr = 0; e_addr = reqAddrI_mem;
            end
        end
    endtask

    task automatic compare_all();
        check_value("mem_req", mem_req, m_active);
        check_value("mem_we", mem_we, m_active && m_owner_wr);
        check_value("mem_addr", mem_addr, e_addr);
        check_value("mem_wdata", mem_wdata, e_wdata);
        check_value("busy", busy, m_active || m_in_resp);
        check_value("read_ready_I", read_ready_I, e_rdy_i);
        check_value("read_ready_D", read_ready_D, e_rdy_d);
        check_value("written_ack_D", written_data_ack_D, e_ack);
        check_value("instr_from_mem", instr_from_mem, e_instr);
        check_value("data_from_mem", data_from_mem, e_data);
        checks++;
        if (int'(read_ready_I) + int'(read_ready_D) + int'(written_data_ack_D) > 1) begin
            errors++;
            $display("FAIL pulse_onehot: got %b%b%b expected at most one",
                     read_ready_I, read_ready_D, written_data_ack_D);
        end
    endtask

    // Inputs are changed 1 time unit after a rising edge; the model consumes them
    // before the next edge, and outputs are compared 1 unit after that edge.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [ADDR_W-1:0] d_addr_saved;
        reset = 1; reqI_mem = 0; reqAddrI_mem = '0; reqD_mem = 0; reqD_write = 0;
        reqAddrD_mem = '0; reqD_wdata = '0; mem_rdata = '0; mem_ready = 0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        compare_all();
        reset = 0;

        // Single I-read: request in cycle 0, mem_ready in cycle 3.
        reqI_mem = 1; reqAddrI_mem = 20'h00ABC;
        step();
        check_value("t1_req_c1", mem_req, 1'b1);
        check_value("t1_addr_c1", mem_addr, 20'h00ABC);
        step();
        step();
        check_value("t1_req_c3", mem_req, 1'b1);
        mem_ready = 1; mem_rdata = {16'hDEAD, 108'h0, 4'h1};
        step();
        check_value("t1_rdy_c4", read_ready_I, 1'b1);
        check_value("t1_instr_c4", instr_from_mem, {16'hDEAD, 108'h0, 4'h1});
        check_value("t1_req_c4", mem_req, 1'b0);
        mem_ready = 0; reqI_mem = 0;
        step();
        check_value("t1_busy_c5", busy, 1'b0);

        // Randomized traffic: caches hold requests until the model's response pulse,
        // memory pulses mem_ready at random (also in IDLE and RESP), write data churns.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!reqI_mem) begin
                reqI_mem = ($urandom % 2) == 0;
                reqAddrI_mem = ADDR_W'($urandom);
            end else if (e_rdy_i) begin
                reqI_mem = ($urandom % 4) == 0;
            end
            if (!reqD_mem) begin
                reqD_mem = ($urandom % 2) == 0;
                reqD_write = ($urandom % 3) == 0;
                reqAddrD_mem = ADDR_W'($urandom);
            end else if (e_rdy_d || e_ack) begin
                reqD_mem = ($urandom % 4) == 0;
                reqD_write = ($urandom % 3) == 0;
            end else if (m_active) begin
                reqD_write = $urandom % 2 == 0;
            end
            reqD_wdata = rand_line();
            mem_rdata = rand_line();
            mem_ready = ($urandom % 3) == 0;
            step();
        end

        // Drain to idle, then start a D read and reset it between edges.
        reqI_mem = 0; reqD_mem = 0; mem_ready = 1;
        for (int k = 0; k < 4; k++) step();
        mem_ready = 0; reqD_mem = 1; reqD_write = 0; reqAddrD_mem = 20'h0F0F0;
        step();
        check_value("t5_req_before", mem_req, 1'b1);
        #2;
        reset = 1;
        #1;
        model_reset();
        check_value("t5_req_async", mem_req, 1'b0);
        check_value("t5_busy_async", busy, 1'b0);
        check_value("t5_instr_async", instr_from_mem, '0);
        check_value("t5_data_async", data_from_mem, '0);
        @(posedge clk); #1;
        reset = 0; reqD_mem = 0; mem_ready = 1;
        step();
        check_value("t5_no_pulse", read_ready_D, 1'b0);
        mem_ready = 0;
        reqI_mem = 1; reqAddrI_mem = 20'h11111;
        reqD_mem = 1; reqD_write = 0; reqAddrD_mem = 20'h22222;
        d_addr_saved = reqAddrD_mem;
        step();
        check_value("t5_tie_to_d", mem_addr, d_addr_saved);
        mem_ready = 1; mem_rdata = rand_line();
        step();
        check_value("t5_d_resp", read_ready_D, 1'b1);
        reqD_mem = 0; mem_ready = 0;
        step();
        step();
        check_value("t5_then_i", mem_addr, 20'h11111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
